// File: rtl/parity_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_tx_pkg
//  Description : Shared types and line-level constants for the parity serial
//                transmitter and its matching receive-side checker.
//                  tx_state_t  - frame FSM state encoding
//                  LINE_IDLE   - level of the serial line when idle / stop bit
//                  LINE_START  - level of the start bit
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage : parity_tx_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : parity_calc
//  Description : Combinational parity generator. Produces the bit that makes
//                the ones-count of {data, parity} even (odd_sel=0) or odd
//                (odd_sel=1). Shared by the transmitter and the receive-side
//                checker so both ends agree on the definition.
//  Ports       : data    in  [DATA_W-1:0]  word to protect
//                odd_sel in  1             0 = even parity, 1 = odd parity
//                parity  out 1             parity bit to append
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              odd_sel,
    output logic              parity
);

    assign parity = (^data) ^ odd_sel;

endmodule : parity_calc
`default_nettype wire

// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_serial_tx
//  Description : Parallel-to-serial transmitter. Each accepted word is sent as
//                start bit (0), DATA_W data bits LSB first, one parity bit and
//                a stop bit (1); every bit is held for CLKS_PER_BIT clocks.
//                All outputs are registered.
//  Ports       : clk        in  1       system clock, rising edge
//                rst_n      in  1       asynchronous active-low reset
//                in_data    in  DATA_W  word to send, sampled on handshake
//                in_valid   in  1       producer has a word
//                in_ready   out 1       high only while IDLE
//                tx         out 1       serial line, idles high
//                busy       out 1       frame in progress
//                parity_out out 1       parity of current / last frame
//                done       out 1       one-cycle pulse after frame completes
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              parity_out,
    output logic              done
);

    localparam int c_bit_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_bit_cnt_w-1:0] c_bit_last = c_bit_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0]     c_idx_last = c_idx_w'(DATA_W - 1);
    localparam logic                   c_odd_sel  = (PARITY_ODD != 0);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    tx_state_t              r_state;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [DATA_W-1:0]      r_data;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_done;

    tx_state_t              w_state_nxt;
    logic [c_bit_cnt_w-1:0] w_bit_cnt_nxt;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic [DATA_W-1:0]      w_data_nxt;
    logic                   w_parity_nxt;
    logic                   w_tx_nxt;
    logic                   w_done_nxt;
    logic                   w_bit_end;
    logic                   w_parity_in;

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity_calc (
        .data    (in_data),
        .odd_sel (c_odd_sel),
        .parity  (w_parity_in)
    );

    assign w_bit_end = (r_bit_cnt == c_bit_last);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed from the next
    // state so that the registered outputs line up with the state register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_data;
        w_parity_nxt  = r_parity;
        w_done_nxt    = 1'b0;
        w_tx_nxt      = LINE_IDLE;

        case (r_state)
            IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone is a handshake
                if (in_valid) begin
                    w_state_nxt   = START;
                    w_data_nxt    = in_data;
                    w_parity_nxt  = w_parity_in;
                    w_bit_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt   = STOP;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = '0;
                w_idx_nxt     = '0;
            end
        endcase

        case (w_state_nxt)
            START:   w_tx_nxt = LINE_START;
            DATA:    w_tx_nxt = w_data_nxt[w_idx_nxt];
            PARITY:  w_tx_nxt = w_parity_nxt;
            default: w_tx_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_tx      <= LINE_IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_parity  <= w_parity_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_ready   <= (w_state_nxt == IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign in_ready   = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign parity_out = r_parity;
    assign done       = r_done;

endmodule : parity_serial_tx
`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_serial_tx
//  Description : Directed self-checking bench for parity_serial_tx. Two
//                instances share the stimulus: one even-parity (default) and
//                one odd-parity. Expected line levels are built from the
//                frame format and hand-computed parity bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;

    logic e_ready, e_tx, e_busy, e_par, e_done;
    logic o_ready, o_tx, o_busy, o_par, o_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    parity_serial_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (0)
    ) u_dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (e_ready),
        .tx         (e_tx),
        .busy       (e_busy),
        .parity_out (e_par),
        .done       (e_done)
    );

    parity_serial_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (1)
    ) u_dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (o_ready),
        .tx         (o_tx),
        .busy       (o_busy),
        .parity_out (o_par),
        .done       (o_done)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller has placed data on in_data with in_valid=1 at a negedge while
    // in_ready=1, so the handshake happens at the next rising edge. exp_par is
    // the even parity; the odd instance must send its complement. After the
    // handshake the inputs are switched to nxt_data / nxt_valid, which the DUT
    // must ignore until the frame completes.
    task automatic run_frame(input logic [DW-1:0] data, input logic exp_par,
                             input logic [DW-1:0] nxt_data, input logic nxt_valid);
        logic e_exp;
        logic o_exp;
        int   b;
        for (int k = 0; k < (DW + 3) * CPB; k++) begin
            @(negedge clk);
            b = k / CPB;
            if (b == 0) begin
                e_exp = 1'b0; o_exp = 1'b0;
            end else if (b <= DW) begin
                e_exp = data[b-1]; o_exp = data[b-1];
            end else if (b == DW + 1) begin
                e_exp = exp_par; o_exp = ~exp_par;
            end else begin
                e_exp = 1'b1; o_exp = 1'b1;
            end
            check_value("tx_even", {31'd0, e_tx}, {31'd0, e_exp});
            check_value("tx_odd", {31'd0, o_tx}, {31'd0, o_exp});
            check_value("busy_in_frame", {30'd0, e_busy, o_busy}, 32'd3);
            check_value("ready_in_frame", {30'd0, e_ready, o_ready}, 32'd0);
            check_value("done_in_frame", {30'd0, e_done, o_done}, 32'd0);
            if (k == 0) begin
                check_value("parity_even", {31'd0, e_par}, {31'd0, exp_par});
                check_value("parity_odd", {31'd0, o_par}, {31'd0, ~exp_par});
                in_data  = nxt_data;
                in_valid = nxt_valid;
            end
        end
        // First cycle back in IDLE: done pulse, handshake open, parity held
        @(negedge clk);
        check_value("done_pulse", {30'd0, e_done, o_done}, 32'd3);
        check_value("busy_end", {30'd0, e_busy, o_busy}, 32'd0);
        check_value("ready_end", {30'd0, e_ready, o_ready}, 32'd3);
        check_value("tx_idle", {30'd0, e_tx, o_tx}, 32'd3);
        check_value("parity_hold_even", {31'd0, e_par}, {31'd0, exp_par});
        check_value("rx_check_even", {31'd0, ^{data, e_par}}, 32'd0);
        check_value("rx_check_odd", {31'd0, ^{data, o_par}}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rst_tx", {30'd0, e_tx, o_tx}, 32'd3);
        check_value("rst_ready", {30'd0, e_ready, o_ready}, 32'd3);
        check_value("rst_busy", {30'd0, e_busy, o_busy}, 32'd0);
        check_value("rst_done", {30'd0, e_done, o_done}, 32'd0);
        check_value("rst_parity", {30'd0, e_par, o_par}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero word
        in_data = 8'h00; in_valid = 1'b1;
        run_frame(8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_value("done_one_cycle", {30'd0, e_done, o_done}, 32'd0);
        check_value("idle_ready", {30'd0, e_ready, o_ready}, 32'd3);

        // Back-to-back with in_valid held high
        in_data = 8'h01; in_valid = 1'b1;
        run_frame(8'h01, 1'b1, 8'h02, 1'b1);
        run_frame(8'h02, 1'b1, 8'h03, 1'b1);
        run_frame(8'h03, 1'b0, 8'hFF, 1'b1);
        // All ones then MSB only
        run_frame(8'hFF, 1'b0, 8'h80, 1'b1);
        run_frame(8'h80, 1'b1, 8'h0A, 1'b1);
        // 0x0A: even parity 0, odd parity 1. 0x55 is offered mid-frame and
        // must only be taken after the frame returns to IDLE.
        run_frame(8'h0A, 1'b0, 8'h55, 1'b1);
        run_frame(8'h55, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of the DATA state
        in_data = 8'hC3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_value("pre_rst_busy", {30'd0, e_busy, o_busy}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_value("async_rst_tx", {30'd0, e_tx, o_tx}, 32'd3);
        check_value("async_rst_busy", {30'd0, e_busy, o_busy}, 32'd0);
        check_value("async_rst_ready", {30'd0, e_ready, o_ready}, 32'd3);
        check_value("async_rst_parity", {30'd0, e_par, o_par}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("no_done_on_abort", {30'd0, e_done, o_done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_value("no_done_after_rst", {30'd0, e_done, o_done}, 32'd0);
        end

        in_data = 8'h0A; in_valid = 1'b1;
        run_frame(8'h0A, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_parity_serial_tx
`default_nettype wire
